// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Self-timed 7-segment scan controller for the calculator board. It shows a
// DATA_W-bit value as pages of NDIG hex digits and drives one digit at a time
// through the active-low anode lines. The block also supports raw segment
// bytes, a per-digit decimal point, per-digit blink, leading-zero blanking,
// and automatic page rotation.
//
// Parameters
//   NDIG      number of digits / anodes
//   DATA_W    width of disp_num, a multiple of 4*NDIG
//   SCAN_DIV  clk cycles each digit stays lit
//   FLASH_DIV clk cycles per blink phase
//   PW        page index width (derived)
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   en        display enable; when low, counters hold and the display is dark
//   disp_num  hex value to show
//   raw_mode  1: show raw_seg bytes instead of decoded hex
//   raw_seg   active-low segment bytes, byte d drives digit d
//   page_sel  manual page select
//   auto_page 1: rotate pages on every full blink period
//   lz_blank  blank leading zeros of the current page (hex mode only)
//   point     decimal point request per digit
//   blink     blink request per digit
//   AN        active-low anode one-hot
//   SEGMENT   active-low {dp,g,f,e,d,c,b,a}
//   page_cur  page currently displayed
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int  NDIG      = 4,
  parameter int  DATA_W    = 64,
  parameter int  SCAN_DIV  = 50000,
  parameter int  FLASH_DIV = 12500000,
  localparam int NPAGE     = DATA_W / (4 * NDIG),
  localparam int PW        = (NPAGE > 1) ? $clog2(NPAGE) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DATA_W-1:0]   disp_num,
  input  logic                raw_mode,
  input  logic [8*NDIG-1:0]   raw_seg,
  input  logic [PW-1:0]       page_sel,
  input  logic                auto_page,
  input  logic                lz_blank,
  input  logic [NDIG-1:0]     point,
  input  logic [NDIG-1:0]     blink,
  output logic [NDIG-1:0]     AN,
  output logic [7:0]          SEGMENT,
  output logic [PW-1:0]       page_cur
);

  localparam int PAGE_W = 4 * NDIG;
  localparam int DW     = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW     = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NDIG - 1);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(NPAGE - 1);

  // The blink phase is the only piece of state with named values: blinking
  // digits are visible in FLASH_SHOW and dark in FLASH_HIDE.
  typedef enum logic {
    FLASH_SHOW = 1'b0,
    FLASH_HIDE = 1'b1
  } flash_phase_t;

  logic [SW-1:0]      scan_cnt;
  logic [DW-1:0]      dig_idx;
  logic [FW-1:0]      flash_cnt;
  flash_phase_t       flash_phase;

  logic [DATA_W-1:0]  frame_num;
  logic [8*NDIG-1:0]  frame_raw;
  logic [NDIG-1:0]    frame_point;
  logic [NDIG-1:0]    frame_blink;
  logic               frame_lz;

  logic               scan_tc;
  logic               frame_start;
  logic               flash_tc;
  logic [PW-1:0]      page_sel_ok;

  logic [PAGE_W-1:0]  page_word;
  logic [PAGE_W-1:0]  upper;
  logic [3:0]         nibble;
  logic [7:0]         raw_byte;
  logic               lz_hit;
  logic [7:0]         seg_next;

  // Active-low hex decode with the decimal point off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // The terminal counts already include en, so nothing below moves while the
  // display is disabled. A frame starts when the last digit's slot expires.
  assign scan_tc     = en && (scan_cnt == SCAN_LAST);
  assign frame_start = scan_tc && (dig_idx == DIG_LAST);
  assign flash_tc    = en && (flash_cnt == FLASH_LAST);

  // Page numbers past the last real page would index beyond disp_num, so
  // they fall back to page 0.
  assign page_sel_ok = (int'(page_sel) < NPAGE) ? page_sel : '0;

  // The slot timer counts the cycles each digit stays lit. When the timer
  // expires, the digit index moves to the next anode and wraps after the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (en) begin
      if (scan_tc) begin
        scan_cnt <= '0;
        dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // The blink timer flips the phase once every FLASH_DIV enabled cycles. A
  // full show/hide period also sets the pace for automatic page rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_cnt   <= '0;
      flash_phase <= FLASH_SHOW;
    end else if (flash_tc) begin
      flash_cnt   <= '0;
      flash_phase <= (flash_phase == FLASH_SHOW) ? FLASH_HIDE : FLASH_SHOW;
    end else if (en) begin
      flash_cnt <= flash_cnt + 1'b1;
    end
  end

  // Everything the digits depend on is sampled once per frame, at the wrap
  // back to digit 0. A value that changes while digits are being scanned
  // can therefore never leave a mix of old and new digits on the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_num   <= '0;
      frame_raw   <= '0;
      frame_point <= '0;
      frame_blink <= '0;
      frame_lz    <= 1'b0;
    end else if (frame_start) begin
      frame_num   <= disp_num;
      frame_raw   <= raw_seg;
      frame_point <= point;
      frame_blink <= blink;
      frame_lz    <= lz_blank;
    end
  end

  // In manual mode the page follows page_sel, but only at a frame boundary.
  // In auto mode the page advances on each hide-to-show edge of the blink
  // phase. Leaving auto mode hands control back to page_sel at the next frame
  // start. With a single page the index is pinned to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      page_cur <= '0;
    end else if (NPAGE == 1) begin
      page_cur <= '0;
    end else if (auto_page) begin
      if (flash_tc && (flash_phase == FLASH_HIDE)) begin
        page_cur <= (page_cur == PAGE_LAST) ? '0 : page_cur + 1'b1;
      end
    end else if (frame_start) begin
      page_cur <= page_sel_ok;
    end
  end

  // Segment pattern for the digit being scanned. upper holds the current
  // digit and everything above it on the page. When upper is zero, the digit
  // is a leading zero (digit 0 is exempt). A blanked digit also drops its
  // point. Blink overrides everything else during the hide phase.
  always_comb begin
    page_word = PAGE_W'(frame_num >> (PAGE_W * int'(page_cur)));
    upper     = page_word >> {dig_idx, 2'b00};
    nibble    = upper[3:0];
    raw_byte  = 8'(frame_raw >> {dig_idx, 3'b000});
    lz_hit    = frame_lz && !raw_mode && (dig_idx != '0) && (upper == '0);
    seg_next  = 8'hFF;

    if (raw_mode) begin
      seg_next = raw_byte;
    end else if (!lz_hit) begin
      seg_next = hex_to_seg(nibble);
    end

    if (frame_point[dig_idx] && !lz_hit) begin
      seg_next[7] = 1'b0;
    end

    if ((flash_phase == FLASH_HIDE) && frame_blink[dig_idx]) begin
      seg_next = 8'hFF;
    end
  end

  // The pins are registered, so they show the digit index one cycle after it
  // moves. Disabling the display darkens the pins on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      AN      <= '1;
      SEGMENT <= 8'hFF;
    end else if (!en) begin
      AN      <= '1;
      SEGMENT <= 8'hFF;
    end else begin
      AN      <= ~(NDIG'(1) << dig_idx);
      SEGMENT <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Bench for seg_scan_ctrl with two pages of four digits and short timers.
// A cycle-count model predicts AN, SEGMENT and page_cur on every cycle.
// Directed scenarios pin literal segment codes for scan order, blanking,
// blink, paging, tear-free latching, raw mode, enable and reset.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int NDIG      = 4;
  localparam int DATA_W    = 32;
  localparam int SCAN_DIV  = 4;
  localparam int FLASH_DIV = 64;
  localparam int NPAGE     = DATA_W / (4 * NDIG);
  localparam int PW        = 1;
  localparam int FRAME     = SCAN_DIV * NDIG;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [DATA_W-1:0]   disp_num;
  logic                raw_mode;
  logic [8*NDIG-1:0]   raw_seg;
  logic [PW-1:0]       page_sel;
  logic                auto_page;
  logic                lz_blank;
  logic [NDIG-1:0]     point;
  logic [NDIG-1:0]     blink;
  logic [NDIG-1:0]     AN;
  logic [7:0]          SEGMENT;
  logic [PW-1:0]       page_cur;

  int compare_count  = 0;
  int mismatch_count = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] num;
    logic        raw_mode;
    logic [31:0] raw_seg;
    logic [0:0]  page_sel;
    logic        auto_page;
    logic        lz;
    logic [3:0]  point;
    logic [3:0]  blink;
  } stim_t;

  stim_t cur;

  seg_scan_ctrl #(
    .NDIG      (NDIG),
    .DATA_W    (DATA_W),
    .SCAN_DIV  (SCAN_DIV),
    .FLASH_DIV (FLASH_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .disp_num  (disp_num),
    .raw_mode  (raw_mode),
    .raw_seg   (raw_seg),
    .page_sel  (page_sel),
    .auto_page (auto_page),
    .lz_blank  (lz_blank),
    .point     (point),
    .blink     (blink),
    .AN        (AN),
    .SEGMENT   (SEGMENT),
    .page_cur  (page_cur)
  );

  always #5 clk = ~clk;

  // Reference model. Timing comes from one count of enabled cycles since
  // reset: digit = (n/SCAN_DIV)%NDIG, phase = (n/FLASH_DIV)%2. Frames latch
  // every FRAME enabled cycles, and auto pages advance every 2*FLASH_DIV.
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int unsigned n_en;
  logic [31:0] m_num;
  logic [31:0] m_raw;
  logic [3:0]  m_point;
  logic [3:0]  m_blink;
  logic        m_lz;
  int          m_page;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  int          exp_page;
  bit          model_valid = 1'b0;

  function automatic logic [7:0] modelSeg(int d, int phase);
    logic [15:0] word;
    logic [7:0]  s;
    bit          blanked;
    word    = 16'(m_num >> (16 * m_page));
    blanked = m_lz && !raw_mode && (d > 0) && ((word >> (4 * d)) == 16'h0);
    if (raw_mode)     s = 8'(m_raw >> (8 * d));
    else if (blanked) s = 8'hFF;
    else              s = hex_tab[4'(word >> (4 * d))];
    if (m_point[d] && !blanked) s = s & 8'h7F;
    if ((phase == 1) && m_blink[d]) s = 8'hFF;
    return s;
  endfunction

  // Advance the model on each rising edge, using the same inputs the DUT
  // samples at that edge.
  always @(posedge clk) begin
    int d;
    int phase;
    if (rst) begin
      n_en = 0; m_num = '0; m_raw = '0; m_point = '0; m_blink = '0; m_lz = 1'b0;
      m_page = 0; exp_an = 4'hF; exp_seg = 8'hFF; model_valid = 1'b1;
    end else if (!en) begin
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
    end else begin
      d       = (n_en / SCAN_DIV) % NDIG;
      phase   = (n_en / FLASH_DIV) % 2;
      exp_an  = 4'(~(4'b0001 << d));
      exp_seg = modelSeg(d, phase);
      n_en++;
      if (auto_page) begin
        if (n_en % (2 * FLASH_DIV) == 0) m_page = (m_page + 1) % NPAGE;
      end else if (n_en % FRAME == 0) begin
        m_page = int'(page_sel);
      end
      if (n_en % FRAME == 0) begin
        m_num = disp_num; m_raw = raw_seg; m_point = point; m_blink = blink; m_lz = lz_blank;
      end
    end
    exp_page = m_page;
  end

  // Single comparison point, shared by the streaming check and the directed
  // literal checks.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      if (mismatch_count <= 30)
        $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    compare_count++;
    mismatch_count++;
    $display("[TB] FAIL %s at %0t: got timeout, expected event", name, $time);
  endtask

  // Compare every cycle once the first reset edge has seeded the model.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("stream_an", 32'(AN), 32'(exp_an));
      checkOutput("stream_seg", 32'(SEGMENT), 32'(exp_seg));
      checkOutput("stream_page", 32'(page_cur), 32'(exp_page));
    end
  end

  task automatic applyStimulus(input stim_t s);
    rst       = s.rst;
    en        = s.en;
    disp_num  = s.num;
    raw_mode  = s.raw_mode;
    raw_seg   = s.raw_seg;
    page_sel  = s.page_sel;
    auto_page = s.auto_page;
    lz_blank  = s.lz;
    point     = s.point;
    blink     = s.blink;
  endtask

  // Wait for AN to change to digit 0, which marks the start of a frame.
  task automatic waitFrameStart();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = AN;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (AN == 4'hE && prev != 4'hE) found = 1'b1;
      prev = AN;
    end
    if (!found) timeoutFail("frame_start_wait");
  endtask

  // Two frame starts guarantee that the frame shown was latched after the
  // caller's last input change.
  task automatic settleFrame();
    waitFrameStart();
    waitFrameStart();
  endtask

  task automatic waitDigit(input int d);
    bit found;
    found = (AN == 4'(~(4'b0001 << d)));
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      found = (AN == 4'(~(4'b0001 << d)));
    end
    if (!found) timeoutFail("digit_wait");
  endtask

  task automatic checkDigit(input string name, input int d, input logic [7:0] seg);
    waitDigit(d);
    checkOutput(name, 32'(SEGMENT), 32'(seg));
  endtask

  task automatic countHoldE(input string name);
    int hold;
    hold = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (AN == 4'hE) hold++;
      else break;
    end
    checkOutput(name, 32'(hold), 32'(SCAN_DIV));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog at %0t: got no finish, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int saw_on, saw_off, other_bad, dark_bad, interval;
    logic [PW-1:0] last_page;
    bit changed;

    cur = '{rst: 1'b1, en: 1'b1, num: '0, raw_mode: 1'b0, raw_seg: '0, page_sel: '0,
            auto_page: 1'b0, lz: 1'b0, point: '0, blink: '0};
    applyStimulus(cur);
    @(negedge clk);
    checkOutput("reset_an", 32'(AN), 32'h0000_000F);
    checkOutput("reset_seg", 32'(SEGMENT), 32'h0000_00FF);
    checkOutput("reset_page", 32'(page_cur), 32'h0);

    // The first slot after reset shows the still-empty frame.
    cur.rst = 1'b0; cur.num = 32'h0000_12AF;
    applyStimulus(cur);
    @(negedge clk);
    checkOutput("first_an", 32'(AN), 32'h0000_000E);
    checkOutput("first_seg", 32'(SEGMENT), 32'h0000_00C0);

    $display("[TB] scan order and hex decode");
    waitFrameStart();
    checkOutput("scan_d0", 32'(SEGMENT), 32'h8E);
    countHoldE("scan_hold");
    checkDigit("scan_d1", 1, 8'h88);
    checkDigit("scan_d2", 2, 8'hA4);
    checkDigit("scan_d3", 3, 8'hF9);

    $display("[TB] leading zero blanking");
    cur.num = 32'h0000_0030; cur.lz = 1'b1; cur.point = 4'b0001;
    applyStimulus(cur);
    settleFrame();
    checkDigit("lz_d0", 0, 8'h40);
    checkDigit("lz_d1", 1, 8'hB0);
    checkDigit("lz_d2", 2, 8'hFF);
    checkDigit("lz_d3", 3, 8'hFF);
    cur.num = 32'h0000_0000; cur.point = 4'b0000;
    applyStimulus(cur);
    settleFrame();
    checkDigit("lz0_d0", 0, 8'hC0);
    checkDigit("lz0_d1", 1, 8'hFF);
    checkDigit("lz0_d2", 2, 8'hFF);
    checkDigit("lz0_d3", 3, 8'hFF);
    cur.num = 32'h0000_0030; cur.point = 4'b1000;
    applyStimulus(cur);
    settleFrame();
    checkDigit("lz_pt_d1", 1, 8'hB0);
    checkDigit("lz_pt_d3", 3, 8'hFF);

    $display("[TB] blink");
    cur.num = 32'h0000_8888; cur.lz = 1'b0; cur.point = 4'b0000; cur.blink = 4'b0010;
    applyStimulus(cur);
    settleFrame();
    saw_on = 0; saw_off = 0; other_bad = 0; dark_bad = 0;
    for (int i = 0; i < 10 * FRAME; i++) begin
      @(negedge clk);
      if (AN == 4'hD) begin
        if (SEGMENT == 8'h80) saw_on = 1;
        else if (SEGMENT == 8'hFF) saw_off = 1;
        else other_bad++;
      end else if (AN == 4'hF) begin
        dark_bad++;
      end else if (SEGMENT != 8'h80) begin
        other_bad++;
      end
    end
    checkOutput("blink_on_seen", 32'(saw_on), 32'h1);
    checkOutput("blink_off_seen", 32'(saw_off), 32'h1);
    checkOutput("blink_others", 32'(other_bad), 32'h0);
    checkOutput("blink_an_driven", 32'(dark_bad), 32'h0);

    $display("[TB] paging");
    cur.num = 32'hDEAD_BEEF; cur.blink = 4'b0000; cur.page_sel = 1'b0;
    applyStimulus(cur);
    settleFrame();
    checkOutput("page0_cur", 32'(page_cur), 32'h0);
    checkDigit("page0_d0", 0, 8'h8E);
    checkDigit("page0_d1", 1, 8'h86);
    checkDigit("page0_d2", 2, 8'h86);
    checkDigit("page0_d3", 3, 8'h83);
    cur.page_sel = 1'b1;
    applyStimulus(cur);
    settleFrame();
    checkOutput("page1_cur", 32'(page_cur), 32'h1);
    checkDigit("page1_d0", 0, 8'hA1);
    checkDigit("page1_d1", 1, 8'h88);
    checkDigit("page1_d2", 2, 8'h86);
    checkDigit("page1_d3", 3, 8'hA1);

    cur.auto_page = 1'b1;
    applyStimulus(cur);
    last_page = page_cur;
    changed = 1'b0;
    for (int i = 0; i < 4 * FLASH_DIV && !changed; i++) begin
      @(negedge clk);
      changed = (page_cur != last_page);
    end
    if (!changed) begin
      timeoutFail("auto_first_toggle");
    end else begin
      last_page = page_cur;
      interval  = 0;
      changed   = 1'b0;
      for (int i = 0; i < 4 * FLASH_DIV && !changed; i++) begin
        @(negedge clk);
        interval++;
        changed = (page_cur != last_page);
      end
      checkOutput("auto_interval", 32'(interval), 32'(2 * FLASH_DIV));
    end
    cur.auto_page = 1'b0; cur.page_sel = 1'b0;
    applyStimulus(cur);
    settleFrame();
    checkOutput("auto_off_page", 32'(page_cur), 32'h0);
    checkOutput("auto_off_d0", 32'(SEGMENT), 32'h8E);

    $display("[TB] tear-free latch and raw mode");
    cur.num = 32'h0000_1234;
    applyStimulus(cur);
    settleFrame();
    checkOutput("tear_old_d0", 32'(SEGMENT), 32'h99);
    checkDigit("tear_old_d1", 1, 8'hB0);
    cur.num = 32'h0000_5678;
    applyStimulus(cur);
    checkDigit("tear_old_d2", 2, 8'hA4);
    checkDigit("tear_old_d3", 3, 8'hF9);
    waitFrameStart();
    checkOutput("tear_new_d0", 32'(SEGMENT), 32'h80);
    checkDigit("tear_new_d1", 1, 8'hF8);

    cur.raw_mode = 1'b1; cur.raw_seg = 32'hFFFF_FF00; cur.lz = 1'b1; cur.point = 4'b0010;
    cur.num = 32'h0000_0000;
    applyStimulus(cur);
    settleFrame();
    checkDigit("raw_d0", 0, 8'h00);
    checkDigit("raw_d1", 1, 8'h7F);
    checkDigit("raw_d2", 2, 8'hFF);
    checkDigit("raw_d3", 3, 8'hFF);

    $display("[TB] enable and reset");
    cur.raw_mode = 1'b0; cur.lz = 1'b0; cur.point = 4'b0000; cur.num = 32'h0000_12AF;
    applyStimulus(cur);
    settleFrame();
    checkDigit("en_pre_d2", 2, 8'hA4);
    cur.en = 1'b0;
    applyStimulus(cur);
    @(negedge clk);
    checkOutput("en_off_an", 32'(AN), 32'h0000_000F);
    checkOutput("en_off_seg", 32'(SEGMENT), 32'h0000_00FF);
    dark_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (AN != 4'hF || SEGMENT != 8'hFF) dark_bad++;
    end
    checkOutput("en_off_hold", 32'(dark_bad), 32'h0);
    cur.en = 1'b1;
    applyStimulus(cur);
    @(negedge clk);
    checkOutput("en_resume_an", 32'(AN), 32'h0000_000B);
    checkOutput("en_resume_seg", 32'(SEGMENT), 32'h0000_00A4);

    cur.num = 32'hDEAD_BEEF; cur.page_sel = 1'b1;
    applyStimulus(cur);
    settleFrame();
    checkOutput("rst_pre_page", 32'(page_cur), 32'h1);
    waitDigit(1);
    cur.rst = 1'b1;
    applyStimulus(cur);
    @(negedge clk);
    checkOutput("rst_mid_an", 32'(AN), 32'h0000_000F);
    checkOutput("rst_mid_seg", 32'(SEGMENT), 32'h0000_00FF);
    checkOutput("rst_mid_page", 32'(page_cur), 32'h0);
    cur.rst = 1'b0;
    applyStimulus(cur);
    @(negedge clk);
    checkOutput("rst_restart_an", 32'(AN), 32'h0000_000E);
    checkOutput("rst_restart_seg", 32'(SEGMENT), 32'h0000_00C0);
    countHoldE("rst_restart_hold");

    repeat (2 * FRAME) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
